// File: rtl/riscv_pkg.sv
// Shared fetch-side constants: the canonical NOP encoding and the fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch.sv
// Single-outstanding instruction fetch with decode stall, flush/redirect kill and a holding register.
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
//
// state   | meaning
// FS_REQ  | fetch request driven at fetch_pc
// FS_WAIT | one request outstanding, waiting for its response
// FS_HOLD | response captured in the holding register, decode stalled
module ifetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 'h1000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic            instr_valid,
    output logic            fetch_trap
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [31:0]     r_hold_data;
    logic            r_instr_valid;
    logic            r_kill;
    logic            r_trap;

    logic            w_discard;
    logic            w_req_fire;
    logic            w_misalign;
    logic [XLEN-1:0] w_redir_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign w_redir_pc = redirect_pc;
    assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign w_redir_pc = redirect_pc & ~XLEN'(3);
    assign w_misalign = 1'b0;
`endif

    assign w_discard      = flush | redirect_valid;
    // Gated by resetn so no request leaks out while reset is held, yet the first
    // request appears in the very first cycle after release.
    assign imem_req_valid = resetn && (r_state == FS_REQ) && !r_trap;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = r_fetch_pc;

    assign instr       = r_instr;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign fetch_trap  = r_trap;

    // Responses outside FS_WAIT are never ours, so stale pre-reset responses are ignored there.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= FS_REQ;
            r_fetch_pc    <= RESET_PC;
            r_pc          <= RESET_PC;
            r_instr       <= NOP;
            r_hold_data   <= NOP;
            r_instr_valid <= 1'b0;
            r_kill        <= 1'b0;
            r_trap        <= 1'b0;
        end else if (w_discard) begin
            r_instr       <= NOP;
            r_instr_valid <= 1'b0;
            r_trap        <= w_misalign;
            if (w_misalign)
                r_pc <= redirect_pc;
            if (redirect_valid)
                r_fetch_pc <= w_redir_pc;
            case (r_state)
                FS_REQ: begin
                    if (w_req_fire) begin
                        r_state <= FS_WAIT;
                        r_kill  <= 1'b1;
                    end
                end
                FS_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state <= FS_REQ;
                        r_kill  <= 1'b0;
                    end else begin
                        r_kill <= 1'b1;
                    end
                end
                default: r_state <= FS_REQ;
            endcase
        end else begin
            if (!stall) begin
                r_instr       <= NOP;
                r_instr_valid <= 1'b0;
            end
            case (r_state)
                FS_REQ: begin
                    if (w_req_fire) begin
                        r_state <= FS_WAIT;
                        r_kill  <= 1'b0;
                    end
                end
                FS_WAIT: begin
                    if (imem_rsp_valid && r_kill) begin
                        r_kill  <= 1'b0;
                        r_state <= FS_REQ;
                    end else if (imem_rsp_valid && !stall) begin
                        r_instr       <= imem_rsp_data;
                        r_pc          <= r_fetch_pc;
                        r_instr_valid <= 1'b1;
                        r_fetch_pc    <= r_fetch_pc + XLEN'(4);
                        r_state       <= FS_REQ;
                    end else if (imem_rsp_valid) begin
                        r_hold_data <= imem_rsp_data;
                        r_state     <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (!stall) begin
                        r_instr       <= r_hold_data;
                        r_pc          <= r_fetch_pc;
                        r_instr_valid <= 1'b1;
                        r_fetch_pc    <= r_fetch_pc + XLEN'(4);
                        r_state       <= FS_REQ;
                    end
                end
                default: r_state <= FS_REQ;
            endcase
        end
    end

endmodule
